// File: rtl/noise_sched_pkg.sv
// Shared types and default widths for the noise burst scheduler.
package noise_sched_pkg;

  localparam int NS_CNT_W  = 16;
  localparam int NS_BCNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } ns_state_e;

endpackage

// File: rtl/noise_rate_div.sv
// Strobe divider: counts 0..period while enabled and ticks on the terminal count.
module noise_rate_div
  import noise_sched_pkg::*;
#(
  parameter int CNT_W = NS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/noise_sched.sv
// Noise LFSR burst scheduler: strobes lfsr_en every rate_div+1 cycles for burst_len strobes.
// Define NOISE_SCHED_GAP_EN to enable repeat/gap looping; otherwise every burst ends in DONE.
module noise_sched
  import noise_sched_pkg::*;
#(
  parameter int CNT_W  = NS_CNT_W,
  parameter int BCNT_W = NS_BCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  rate_div,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic              repeat_en,
  output logic              lfsr_en,
  output logic              gate,
  output logic              busy,
  output logic              done,
  output logic [BCNT_W-1:0] bursts_done
);

  ns_state_e         state_q, state_d;
  logic [CNT_W-1:0]  rate_q, rate_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [BCNT_W-1:0] bdone_q, bdone_d;
  logic              gate_q, gate_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick, div_en, div_clr, burst_end;

`ifdef NOISE_SCHED_GAP_EN
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic              rep_q, rep_d;
`else
  logic              unused_cfg;
  assign unused_cfg = ^{gap_len, repeat_en};
`endif

  // Divider only runs in RUN; holding it cleared elsewhere gives every burst a fresh phase.
  assign div_en  = (state_q == S_RUN);
  assign div_clr = (state_q != S_RUN);

  noise_rate_div #(.CNT_W(CNT_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .en     (div_en),
    .period (rate_q),
    .tick   (tick)
  );

  assign burst_end = (scnt_q == burst_q - 1'b1);

  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    burst_d = burst_q;
    scnt_d  = scnt_q;
    bdone_d = bdone_q;
`ifdef NOISE_SCHED_GAP_EN
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    rep_d   = rep_q;
`endif
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          rate_d  = rate_div;
          burst_d = (burst_len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : burst_len;
          scnt_d  = '0;
          bdone_d = '0;
`ifdef NOISE_SCHED_GAP_EN
          gap_d   = gap_len;
          rep_d   = repeat_en;
`endif
          state_d = S_RUN;
        end
        S_RUN: if (tick) begin
          if (burst_end) begin
            scnt_d  = '0;
            bdone_d = bdone_q + 1'b1;
`ifdef NOISE_SCHED_GAP_EN
            if (rep_q && gap_q != '0) begin
              state_d = S_GAP;
              gcnt_d  = '0;
            end else if (rep_q) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
`ifdef NOISE_SCHED_GAP_EN
        S_GAP: begin
          if (gcnt_q == gap_q - 1'b1) state_d = S_RUN;
          else                        gcnt_d  = gcnt_q + 1'b1;
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    gate_d = (state_d == S_RUN);
    busy_d = (state_d == S_RUN) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rate_q  <= '0;
      burst_q <= '0;
      scnt_q  <= '0;
      bdone_q <= '0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NOISE_SCHED_GAP_EN
      gap_q   <= '0;
      gcnt_q  <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      burst_q <= burst_d;
      scnt_q  <= scnt_d;
      bdone_q <= bdone_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NOISE_SCHED_GAP_EN
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      rep_q   <= rep_d;
`endif
    end
  end

  // An abort (stop or reset) swallows a strobe landing in the same cycle.
  assign lfsr_en     = tick && !stop && !rst;
  assign gate        = gate_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign bursts_done = bdone_q;

endmodule

// File: tb/tb_noise_sched.sv
// Randomized scoreboard bench for noise_sched: a timeline model predicts strobe/done events and gate/busy windows.
module tb_noise_sched;

  localparam int CW   = 16;
  localparam int BW   = 2;
  localparam int BMOD = 1 << BW;
  localparam int MAXC = 40000;
`ifdef NOISE_SCHED_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop, repeat_en;
  logic [CW-1:0] rate_div, burst_len, gap_len;
  logic          lfsr_en, gate, busy, done;
  logic [BW-1:0] bursts_done;

  int cyc   = 0;
  int nvec  = 0;
  int nfail = 0;

  bit exp_gate [MAXC];
  bit exp_busy [MAXC];
  bit bd_chk   [MAXC];
  int exp_bd   [MAXC];

  typedef struct { int c; int bd; } done_t;
  int    lfsr_q [$];
  done_t done_q [$];

  noise_sched #(.CNT_W(CW), .BCNT_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .rate_div    (rate_div),
    .burst_len   (burst_len),
    .gap_len     (gap_len),
    .repeat_en   (repeat_en),
    .lfsr_en     (lfsr_en),
    .gate        (gate),
    .busy        (busy),
    .done        (done),
    .bursts_done (bursts_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    nvec++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int t, input bit g, input bit b, input int bd);
    if (t < MAXC) begin
      exp_gate[t] = g;
      exp_busy[t] = b;
      exp_bd[t]   = bd;
      bd_chk[t]   = 1'b1;
    end
  endtask

  // Timeline of one accepted sequence: each burst is eb strobes spaced r+1 cycles apart,
  // optionally followed by g idle gap cycles when looping. An abort at cycle s truncates it.
  task automatic plan(input int c0, input int r, input int b, input int g, input bit rep,
                      input int s, output int last);
    int t, eb, bd;
    bit rp;
    t    = c0 + 1;
    bd   = 0;
    eb   = (b == 0) ? 1 : b;
    rp   = rep && GAP_EN;
    last = -1;
    while (last < 0) begin
      for (int k = 0; k < eb && last < 0; k++)
        for (int j = 0; j <= r && last < 0; j++) begin
          if (s >= 0 && t > s) last = s;
          else begin
            mark(t, 1'b1, 1'b1, bd);
            if (j == r && (s < 0 || t < s)) begin
              lfsr_q.push_back(t);
              if (k == eb - 1) bd = (bd + 1) % BMOD;
            end
            t++;
          end
        end
      if (last < 0 && rp)
        for (int j = 0; j < g && last < 0; j++) begin
          if (s >= 0 && t > s) last = s;
          else begin
            mark(t, 1'b0, 1'b1, bd);
            t++;
          end
        end
      if (last < 0 && !rp) begin
        if (s >= 0 && t > s) last = s;
        else begin
          mark(t, 1'b0, 1'b0, bd);
          done_q.push_back('{t, bd});
          last = t;
        end
      end
      if (last < 0 && t > c0 + 4000) last = t;
    end
    if (last + 1 < MAXC) begin
      bd_chk[last + 1] = 1'b1;
      exp_bd[last + 1] = bd;
    end
  endtask

  task automatic run_seq(input int r, input int b, input int g, input bit rep, input int srel,
                         input bit rst_abort, input bit busy_starts);
    int c0, s, last;
    c0 = cyc;
    s  = (srel < 0) ? -1 : c0 + srel;
    rate_div  = CW'(r);
    burst_len = CW'(b);
    gap_len   = CW'(g);
    repeat_en = rep;
    start     = 1'b1;
    plan(c0, r, b, g, rep, s, last);
    if (rst_abort && last + 1 < MAXC) exp_bd[last + 1] = 0;
    step();
    while (cyc <= last) begin
      start     = (busy_starts && $urandom_range(0, 2) == 0) || (cyc == s);
      stop      = !rst_abort && (cyc == s);
      rst       = rst_abort && (cyc == s);
      rate_div  = CW'($urandom);
      burst_len = CW'($urandom);
      gap_len   = CW'($urandom);
      repeat_en = 1'($urandom);
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("gate", int'(gate), int'(exp_gate[cyc]));
      chk("busy", int'(busy), int'(exp_busy[cyc]));
      if (bd_chk[cyc]) chk("bursts_done", int'(bursts_done), exp_bd[cyc]);
      while (lfsr_q.size() > 0 && lfsr_q[0] < cyc) begin
        chk("lfsr_missed_cyc", cyc, lfsr_q[0]);
        void'(lfsr_q.pop_front());
      end
      if (lfsr_en) begin
        if (lfsr_q.size() == 0) chk("lfsr_spurious_cyc", cyc, -1);
        else begin
          chk("lfsr_cyc", cyc, lfsr_q[0]);
          void'(lfsr_q.pop_front());
        end
      end
      while (done_q.size() > 0 && done_q[0].c < cyc) begin
        chk("done_missed_cyc", cyc, done_q[0].c);
        void'(done_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_spurious_cyc", cyc, -1);
        else begin
          chk("done_cyc", cyc, done_q[0].c);
          chk("done_bursts", int'(bursts_done), done_q[0].bd);
          void'(done_q.pop_front());
        end
      end
    end
  end

  initial begin
    int r, b, g, dn, srel;
    bit rep;
    rst = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    rate_div = '0; burst_len = '0; gap_len = '0;
    repeat (3) step();
    chk("reset_bursts_done", int'(bursts_done), 0);
    chk("reset_lfsr_en", int'(lfsr_en), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    step();

    run_seq(2, 3, 0, 1'b0, -1, 1'b0, 1'b0);   // single burst
    repeat (2) step();
    run_seq(0, 2, 3, 1'b1, 10, 1'b0, 1'b0);   // repeat with gap
    repeat (2) step();
    run_seq(2, 3, 0, 1'b0, 5, 1'b0, 1'b0);    // abort with start in same cycle
    repeat (2) step();
    run_seq(1, 0, 0, 1'b0, -1, 1'b0, 1'b1);   // burst_len 0, starts while busy
    repeat (2) step();
    run_seq(0, 3, 0, 1'b1, 12, 1'b0, 1'b0);   // contiguous repeat
    repeat (2) step();
    run_seq(0, 1, 0, 1'b1, 6, 1'b0, 1'b0);    // bursts_done wrap
    repeat (2) step();
    run_seq(1, 2, 4, 1'b1, 30, 1'b0, 1'b1);
    repeat (2) step();

    // stop beats start while idle
    start = 1'b1; stop = 1'b1; rate_div = 16'd1; burst_len = 16'd2;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_vs_start_busy", int'(busy), 0);
    repeat (3) step();

    for (int i = 0; i < 150; i++) begin
      r   = $urandom_range(0, 4);
      b   = $urandom_range(0, 4);
      g   = $urandom_range(0, 3);
      rep = 1'($urandom);
      dn  = ((b == 0) ? 1 : b) * (r + 1);
      if (rep && GAP_EN)                 srel = $urandom_range(1, 40);
      else if ($urandom_range(0, 2) == 0) srel = $urandom_range(1, dn);
      else                               srel = -1;
      run_seq(r, b, g, rep, srel, 1'b0, 1'($urandom));
      repeat ($urandom_range(1, 3)) step();
    end

    run_seq(1, 3, 0, 1'b1, 4, 1'b1, 1'b0);    // reset mid-RUN
    chk("rst_abort_lfsr_en", int'(lfsr_en), 0);
    chk("rst_abort_gate", int'(gate), 0);
    chk("rst_abort_busy", int'(busy), 0);
    chk("rst_abort_done", int'(done), 0);
    chk("rst_abort_bursts_done", int'(bursts_done), 0);
    repeat (4) step();

    chk("lfsr_left", lfsr_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/noise_sched.md
NOISE_SCHED -- requirements
Module: noise_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of rate_div, burst_len, gap_len and the internal counters.
REQ-002 SHALL have parameter BCNT_W, default 8, width of bursts_done.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a noise sequence.
REQ-006 SHALL have port stop  input  1  abort request.
REQ-007 SHALL have port rate_div  input  CNT_W  strobe period minus one.
REQ-008 SHALL have port burst_len  input  CNT_W  strobes per burst.
REQ-009 SHALL have port gap_len  input  CNT_W  idle cycles between bursts.
REQ-010 SHALL have port repeat  input  1  loop bursts until stop.
REQ-011 SHALL have port lfsr_en  output  1  one-cycle step strobe to the noise LFSR.
REQ-012 SHALL have port gate  output  1  noise output window valid.
REQ-013 SHALL have port busy  output  1  sequence in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port bursts_done  output  BCNT_W  completed-burst count.

Function
REQ-016 SHALL implement states IDLE, RUN, GAP, DONE; all outputs registered.
REQ-017 IDLE: start=1 SHALL latch rate_div, burst_len, gap_len and repeat into shadow registers, clear the divider, clear the strobe count, and enter RUN next cycle.
REQ-018 start SHALL be ignored outside IDLE; inputs SHALL be sampled only at acceptance.
REQ-019 burst_len=0 SHALL be treated as 1.
REQ-020 RUN: the divider SHALL count 0..rate_q; on reaching rate_q, lfsr_en=1 for that cycle and the divider returns to 0.
REQ-021 rate_q=0 SHALL give lfsr_en every RUN cycle; first strobe SHALL occur rate_q+1 cycles after the start cycle.
REQ-022 gate SHALL be 1 exactly in RUN; busy SHALL be 1 in RUN and GAP.
REQ-023 After the burst_q-th strobe: repeat_q=1 and gap_q>0 -> GAP; repeat_q=1 and gap_q=0 -> RUN with a fresh burst; otherwise -> DONE.
REQ-024 GAP SHALL last gap_q cycles with lfsr_en=0, then enter RUN with the divider cleared.
REQ-025 DONE SHALL last one cycle with done=1 and busy=0, then enter IDLE.
REQ-026 bursts_done SHALL increment on each completed burst and wrap from all-ones to 0; it SHALL clear on accepted start.
REQ-027 stop=1 in any state SHALL force IDLE next cycle and suppress lfsr_en in that cycle; no done pulse SHALL occur.
REQ-028 stop SHALL have priority over simultaneous start.

Reset
REQ-029 rst=1 SHALL set state IDLE and clear all counters and shadow registers.
REQ-030 rst=1 SHALL drive lfsr_en, gate, busy, done and bursts_done to 0; reset mid-sequence SHALL abort without a done pulse.

Configuration
REQ-031 With NOISE_SCHED_GAP_EN defined, repeat and gap behaviour SHALL be as in REQ-023/REQ-024.
REQ-032 Without NOISE_SCHED_GAP_EN, repeat and gap_len SHALL be ignored; the ports SHALL remain; every burst SHALL end in DONE.

Structure
REQ-033 Package noise_sched_pkg SHALL hold the state enum and the default CNT_W/BCNT_W constants.
REQ-034 Sub-module noise_rate_div SHALL hold the divider (clear, enable, period in, tick out).

Verification
REQ-035 Single burst: rate_div=2, burst_len=3, repeat=0, start at c0 -> lfsr_en at c3, c6, c9; gate c1-c9; done at c10; bursts_done=1.
REQ-036 Repeat with gap: rate_div=0, burst_len=2, gap_len=3, repeat=1, start at c0 -> lfsr_en at c1, c2, c6, c7; gate=0 in c3-c5.
REQ-037 Abort: stop at c5 during RUN -> IDLE at c6, no lfsr_en at c5, no done; start at c5 ignored.
REQ-038 Edge cases: burst_len=0 -> exactly one strobe; start while busy ignored; gap_len=0 with repeat=1 -> contiguous strobes.
REQ-039 Wrap: BCNT_W=2, 5 bursts -> bursts_done sequence 1, 2, 3, 0, 1.
REQ-040 Macro off: repeat=1, gap_len=4 -> single burst then done; rst mid-RUN -> all outputs 0 next cycle.
